// File: rtl/clock_divider_monitor.sv
// clock_divider_monitor: measures w_clk_mon / r_clk_mon half-periods in clk_in cycles; reports lock, last half-period, sticky fault.
// Optional stall detection (a stopped clock counts as a bad interval) is enabled by defining CLKMON_STALL_DETECT_EN.

module clkmon_chan #(
  parameter int unsigned EXP      = 12,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned TOL      = 0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             clk_mon,
  input  logic             clr_fault,
  output logic             locked,
  output logic             fault,
  output logic [CNT_W-1:0] halfper
);
  localparam int unsigned      GOOD_W    = 4;
  localparam logic [GOOD_W-1:0] LOCK_GOOD = GOOD_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0] RUN_MAX   = '1;

  typedef enum logic [1:0] {S_IDLE, S_ACQ, S_LOCK} state_t;

  state_t            state_q, state_d;
  logic              s1_q, s1_d, s2_q, s2_d, s3_q, s3_d, edge_q, edge_d;
  logic [CNT_W-1:0]  run_q, run_d, halfper_q, halfper_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic              locked_q, locked_d, fault_q, fault_d;
  logic [31:0]       run_ext_c, dev_c;
  logic              in_tol_c, stall_c, ok_ev_c, bad_ev_c;

  // Distance of the just-closed interval from the expected half-period
  assign run_ext_c = 32'(run_q);
  assign dev_c     = (run_ext_c >= 32'(EXP)) ? (run_ext_c - 32'(EXP)) : (32'(EXP) - run_ext_c);
  assign in_tol_c  = (dev_c <= 32'(TOL));

`ifdef CLKMON_STALL_DETECT_EN
  localparam longint unsigned  RUN_MAX_L = (64'd1 << CNT_W) - 64'd1;
  localparam longint unsigned  STALL_L   = 64'(EXP) + 64'(TOL) + 64'd1;
  localparam logic [CNT_W-1:0] STALL_AT  = (STALL_L >= RUN_MAX_L) ? RUN_MAX : CNT_W'(STALL_L);

  logic stalled_q, stalled_d;

  // One stall event per silent stretch; re-armed by the next edge
  assign stall_c = !edge_q && !stalled_q && (state_q != S_IDLE) && (run_q == STALL_AT);

  always_comb begin
    stalled_d = edge_q ? 1'b0 : (stalled_q | stall_c);
  end

  always_ff @(posedge clk_in) begin
    if (rst) stalled_q <= 1'b0;
    else     stalled_q <= stalled_d;
  end
`else
  assign stall_c = 1'b0;
`endif

  always_comb begin
    s1_d      = clk_mon;
    s2_d      = s1_q;
    s3_d      = s2_q;
    edge_d    = s2_q ^ s3_q;
    state_d   = state_q;
    good_d    = good_q;
    locked_d  = locked_q;
    halfper_d = halfper_q;
    fault_d   = fault_q & ~clr_fault;
    run_d     = (run_q == RUN_MAX) ? run_q : run_q + CNT_W'(1);
    ok_ev_c   = 1'b0;
    bad_ev_c  = stall_c;

    if (edge_q) begin
      run_d = CNT_W'(1);
      if (state_q != S_IDLE) begin
        halfper_d = run_q;
        ok_ev_c   = in_tol_c;
        bad_ev_c  = ~in_tol_c;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (edge_q) begin
          state_d = S_ACQ;
          good_d  = '0;
        end
      end
      S_ACQ: begin
        if (ok_ev_c) begin
          good_d = good_q + GOOD_W'(1);
          if (good_d >= LOCK_GOOD) begin
            state_d  = S_LOCK;
            locked_d = 1'b1;
          end
        end else if (bad_ev_c) begin
          good_d = '0;
        end
      end
      S_LOCK: begin
        // A fault set outranks a simultaneous clr_fault
        if (bad_ev_c) begin
          state_d  = S_ACQ;
          good_d   = '0;
          locked_d = 1'b0;
          fault_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q   <= S_IDLE;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      edge_q    <= 1'b0;
      run_q     <= '0;
      halfper_q <= '0;
      good_q    <= '0;
      locked_q  <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s3_q      <= s3_d;
      edge_q    <= edge_d;
      run_q     <= run_d;
      halfper_q <= halfper_d;
      good_q    <= good_d;
      locked_q  <= locked_d;
      fault_q   <= fault_d;
    end
  end

  assign locked  = locked_q;
  assign fault   = fault_q;
  assign halfper = halfper_q;
endmodule

module clock_divider_monitor #(
  parameter int unsigned W_DIV    = 12,
  parameter int unsigned R_DIV    = 20,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned TOL      = 0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             w_clk_mon,
  input  logic             r_clk_mon,
  input  logic             clr_fault,
  output logic             w_locked,
  output logic             r_locked,
  output logic             w_fault,
  output logic             r_fault,
  output logic [CNT_W-1:0] w_halfper,
  output logic [CNT_W-1:0] r_halfper
);
  // Divide-by-1/2 sources toggle every clk_in cycle
  localparam int unsigned W_EXP = (W_DIV <= 2) ? 1 : W_DIV;
  localparam int unsigned R_EXP = (R_DIV <= 2) ? 1 : R_DIV;

  clkmon_chan #(.EXP(W_EXP), .LOCK_CNT(LOCK_CNT), .TOL(TOL), .CNT_W(CNT_W)) u_w_chan (
    .clk_in    (clk_in),
    .rst       (rst),
    .clk_mon   (w_clk_mon),
    .clr_fault (clr_fault),
    .locked    (w_locked),
    .fault     (w_fault),
    .halfper   (w_halfper)
  );

  clkmon_chan #(.EXP(R_EXP), .LOCK_CNT(LOCK_CNT), .TOL(TOL), .CNT_W(CNT_W)) u_r_chan (
    .clk_in    (clk_in),
    .rst       (rst),
    .clk_mon   (r_clk_mon),
    .clr_fault (clr_fault),
    .locked    (r_locked),
    .fault     (r_fault),
    .halfper   (r_halfper)
  );
endmodule

// File: tb/tb_clock_divider_monitor.sv
// Bench for clock_divider_monitor: drives divided clocks with random half-periods and
// compares lock/fault/half-period against an interval-level reference model.
module tb_clock_divider_monitor;
  localparam int unsigned CNT_W  = 16;
  localparam int          LOCK_N = 4;
  localparam int          TOL_TB = 0;

  logic clk_in = 1'b0;
  logic rst = 1'b1, clr_fault = 1'b0;
  logic w_clk_mon = 1'b0, r_clk_mon = 1'b0, w2_clk_mon = 1'b0, r2_clk_mon = 1'b0;
  logic w_locked, r_locked, w_fault, r_fault;
  logic w2_locked, r2_locked, w2_fault, r2_fault;
  logic [CNT_W-1:0] w_halfper, r_halfper, w2_halfper, r2_halfper;

  always #5 clk_in = ~clk_in;

  clock_divider_monitor #(.W_DIV(12), .R_DIV(20), .LOCK_CNT(4), .TOL(0), .CNT_W(CNT_W)) dut (
    .clk_in(clk_in), .rst(rst), .w_clk_mon(w_clk_mon), .r_clk_mon(r_clk_mon),
    .clr_fault(clr_fault), .w_locked(w_locked), .r_locked(r_locked),
    .w_fault(w_fault), .r_fault(r_fault), .w_halfper(w_halfper), .r_halfper(r_halfper)
  );

  clock_divider_monitor #(.W_DIV(2), .R_DIV(3), .LOCK_CNT(4), .TOL(0), .CNT_W(CNT_W)) dut2 (
    .clk_in(clk_in), .rst(rst), .w_clk_mon(w2_clk_mon), .r_clk_mon(r2_clk_mon),
    .clr_fault(clr_fault), .w_locked(w2_locked), .r_locked(r2_locked),
    .w_fault(w2_fault), .r_fault(r2_fault), .w_halfper(w2_halfper), .r_halfper(r2_halfper)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: one update per driven toggle, using the exact interval driven
  int exp_hp [2] = '{12, 20};
  bit m_active [2];
  bit m_locked [2];
  bit m_fault  [2];
  int m_streak [2];
  int m_hp     [2];

  int since   [2];
  int next_hp [2];
  int toggles [2];
  bit run_en  [2];
  bit rand_mode [2];
  int forced_w [$];
  int last_w_iv;
  bit clr_rand_en, clr_req, collide_arm;
  int coll_tog, glitch_tog;

  task automatic model_reset();
    for (int ch = 0; ch < 2; ch++) begin
      m_active[ch] = 1'b0; m_locked[ch] = 1'b0; m_fault[ch] = 1'b0;
      m_streak[ch] = 0; m_hp[ch] = 0; since[ch] = 0; toggles[ch] = 0;
      next_hp[ch] = exp_hp[ch]; run_en[ch] = 1'b0;
    end
    forced_w.delete();
    last_w_iv = 0;
  endtask

  task automatic model_edge(input int ch, input int iv);
    int d;
    if (!m_active[ch]) begin
      m_active[ch] = 1'b1;
      m_streak[ch] = 0;
    end else begin
      m_hp[ch] = (iv > 65535) ? 65535 : iv;
      d = (iv > exp_hp[ch]) ? iv - exp_hp[ch] : exp_hp[ch] - iv;
      if (d <= TOL_TB) begin
        m_streak[ch]++;
        if (m_streak[ch] >= LOCK_N) m_locked[ch] = 1'b1;
      end else begin
        if (m_locked[ch]) m_fault[ch] = 1'b1;
        m_locked[ch] = 1'b0;
        m_streak[ch] = 0;
      end
    end
  endtask

  task automatic pick_hp(input int ch, output int hp);
    int r;
    if (ch == 0 && forced_w.size() > 0) begin
      hp = forced_w.pop_front();
    end else if (!rand_mode[ch]) begin
      hp = exp_hp[ch];
    end else begin
      r = int'($urandom_range(0, 9));
      if (r < 7) hp = exp_hp[ch];
      else begin
        r  = int'($urandom_range(1, 4));
        hp = ($urandom_range(0, 1) != 0) ? exp_hp[ch] + r : exp_hp[ch] - r;
      end
    end
  endtask

  task automatic check_channel(input int ch);
    if (ch == 0) begin
      check_val("w_locked", longint'(w_locked), longint'(m_locked[0]));
      check_val("w_fault", longint'(w_fault), longint'(m_fault[0]));
      check_val("w_halfper", longint'(w_halfper), longint'(m_hp[0]));
    end else begin
      check_val("r_locked", longint'(r_locked), longint'(m_locked[1]));
      check_val("r_fault", longint'(r_fault), longint'(m_fault[1]));
      check_val("r_halfper", longint'(r_halfper), longint'(m_hp[1]));
    end
  endtask

  task automatic check_reset(input string tag);
    check_val({tag, "_w_locked"}, longint'(w_locked), 0);
    check_val({tag, "_r_locked"}, longint'(r_locked), 0);
    check_val({tag, "_w_fault"}, longint'(w_fault), 0);
    check_val({tag, "_r_fault"}, longint'(r_fault), 0);
    check_val({tag, "_w_halfper"}, longint'(w_halfper), 0);
    check_val({tag, "_r_halfper"}, longint'(r_halfper), 0);
  endtask

  // Sample point: 1 time unit after each rising edge
  task automatic tick();
    @(posedge clk_in);
    #1;
    for (int ch = 0; ch < 2; ch++) begin
      since[ch]++;
      if (!rst && m_active[ch] && since[ch] == 5) check_channel(ch);
    end
  endtask

  // Drives clr_fault and the monitored clocks for the coming cycle
  task automatic drive();
    bit win;
    clr_fault = 1'b0;
    win = since[0] >= 4 && since[0] <= exp_hp[0] - 3 && since[1] >= 4 && since[1] <= exp_hp[1] - 3;
    if (win && (clr_req || (clr_rand_en && $urandom_range(0, 15) == 0))) begin
      clr_fault = 1'b1;
      m_fault[0] = 1'b0;
      m_fault[1] = 1'b0;
      clr_req = 1'b0;
    end
    if (collide_arm && last_w_iv == 10 && since[0] == 3) begin
      clr_fault   = 1'b1;
      m_fault[1]  = 1'b0;
      collide_arm = 1'b0;
      coll_tog    = toggles[0];
    end
    for (int ch = 0; ch < 2; ch++) begin
      if (run_en[ch] && since[ch] >= next_hp[ch]) begin
        if (ch == 0) begin
          w_clk_mon = ~w_clk_mon;
          last_w_iv = since[0];
        end else begin
          r_clk_mon = ~r_clk_mon;
        end
        model_edge(ch, since[ch]);
        since[ch] = 0;
        toggles[ch]++;
        pick_hp(ch, next_hp[ch]);
      end
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      drive();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr_fault = 1'b0;
    w_clk_mon = 1'b0;
    r_clk_mon = 1'b0;
    run_en[0] = 1'b0;
    run_en[1] = 1'b0;
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rand_mode[0] = 1'b0; rand_mode[1] = 1'b0;
    clr_rand_en = 1'b0; clr_req = 1'b0; collide_arm = 1'b0;
    coll_tog = -1; glitch_tog = 0;
    model_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
    run_cycles(3);
    check_reset("reset");

    // Nominal lock; exact lock edge is the 5th detected edge
    run_en[0] = 1'b1; run_en[1] = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (toggles[0] == 5 && since[0] == 3) check_val("w_lock_early", longint'(w_locked), 0);
      if (toggles[0] == 5 && since[0] == 4) check_val("w_lock_rise", longint'(w_locked), 1);
      if (toggles[1] == 5 && since[1] == 3) check_val("r_lock_early", longint'(r_locked), 0);
      if (toggles[1] == 5 && since[1] == 4) check_val("r_lock_rise", longint'(r_locked), 1);
      drive();
    end
    check_val("nom_w_halfper", longint'(w_halfper), 12);
    check_val("nom_r_halfper", longint'(r_halfper), 20);
    check_val("nom_w_locked", longint'(w_locked), 1);
    check_val("nom_r_locked", longint'(r_locked), 1);
    check_val("nom_w_fault", longint'(w_fault), 0);
    check_val("nom_r_fault", longint'(r_fault), 0);

    // One stretched write half-period while locked
    forced_w.push_back(14);
    for (int i = 0; i < 130; i++) begin
      tick();
      if (glitch_tog > 0 && toggles[0] == glitch_tog && since[0] == 5) begin
        check_val("glitch_w_locked", longint'(w_locked), 0);
        check_val("glitch_w_fault", longint'(w_fault), 1);
        check_val("glitch_w_halfper", longint'(w_halfper), 14);
      end
      if (glitch_tog > 0 && toggles[0] == glitch_tog + 3 && since[0] == 5)
        check_val("glitch_w_not_yet", longint'(w_locked), 0);
      if (glitch_tog > 0 && toggles[0] == glitch_tog + 4 && since[0] == 5) begin
        check_val("glitch_w_relock", longint'(w_locked), 1);
        check_val("glitch_w_fault_sticky", longint'(w_fault), 1);
      end
      drive();
      if (glitch_tog == 0 && last_w_iv == 14) glitch_tog = toggles[0];
    end

    // Clear, then clear colliding with a fault set
    clr_req = 1'b1;
    for (int i = 0; i < 40 && clr_req; i++) run_cycles(1);
    run_cycles(2);
    check_val("clr_w_fault", longint'(w_fault), 0);
    check_val("clr_r_fault", longint'(r_fault), 0);
    run_cycles(60);
    forced_w.push_back(10);
    collide_arm = 1'b1;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (toggles[0] == coll_tog && since[0] == 5) begin
        check_val("collide_w_fault", longint'(w_fault), 1);
        check_val("collide_w_locked", longint'(w_locked), 0);
      end
      drive();
    end
    clr_req = 1'b1;
    for (int i = 0; i < 40 && clr_req; i++) run_cycles(1);
    run_cycles(2);
    check_val("clr2_w_fault", longint'(w_fault), 0);
    check_val("clr2_r_fault", longint'(r_fault), 0);

    // Randomized half-periods and clears
    rand_mode[0] = 1'b1; rand_mode[1] = 1'b1; clr_rand_en = 1'b1;
    run_cycles(1500);
    rand_mode[0] = 1'b0; rand_mode[1] = 1'b0; clr_rand_en = 1'b0;

    // Reset in the middle of acquisition
    do_reset();
    run_en[0] = 1'b1;
    for (int i = 0; i < 80 && !(toggles[0] == 3 && since[0] >= 5); i++) run_cycles(1);
    do_reset();
    run_cycles(4);
    check_reset("midrst");
    run_en[0] = 1'b1; run_en[1] = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (toggles[0] == 1 && since[0] == 5) check_val("midrst_first_hp", longint'(w_halfper), 0);
      if (toggles[0] == 4 && since[0] == 5) check_val("midrst_w_acq", longint'(w_locked), 0);
      if (toggles[0] == 5 && since[0] == 5) check_val("midrst_w_relock", longint'(w_locked), 1);
      drive();
    end

    // Read clock stops while locked
    check_val("pre_stall_r_locked", longint'(r_locked), 1);
    run_en[1] = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (since[1] == 23) check_val("stall_r_early", longint'(r_locked), 1);
      if (since[1] == 30) begin
`ifdef CLKMON_STALL_DETECT_EN
        check_val("stall_r_locked", longint'(r_locked), 0);
        check_val("stall_r_fault", longint'(r_fault), 1);
`else
        check_val("stall_r_locked", longint'(r_locked), 1);
        check_val("stall_r_fault", longint'(r_fault), 0);
`endif
        check_val("stall_r_halfper", longint'(r_halfper), 20);
      end
      drive();
    end

    // Divide-by-2: toggles every cycle
    for (int j = 0; j < 16; j++) begin
      tick();
      if (j == 7) check_val("div2_lock_early", longint'(w2_locked), 0);
      if (j == 8) begin
        check_val("div2_lock_rise", longint'(w2_locked), 1);
        check_val("div2_halfper", longint'(w2_halfper), 1);
      end
      if (j == 15) begin
        check_val("div2_locked_hold", longint'(w2_locked), 1);
        check_val("div2_fault", longint'(w2_fault), 0);
        check_val("div2_r_idle", longint'(r2_locked), 0);
      end
      w2_clk_mon = ~w2_clk_mon;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/clock_divider_monitor.md
# clock_divider_monitor

Checks that the divided write and read clocks driving the asynchronous FIFO run at their configured ratios. It samples both clocks in the `clk_in` domain, measures every half-period in `clk_in` cycles, and reports per-channel lock status, the last measured half-period, and sticky fault flags. It sits beside the clock divider and observes the same `w_clk` / `r_clk` nets that feed the FIFO.

## Interface
- `W_DIV`, default 12: divide setting of the monitored write clock. Expected half-period is `W_EXP` = 1 if `W_DIV` ≤ 2, else `W_DIV`.
- `R_DIV`, default 20: divide setting of the monitored read clock. Expected half-period is `R_EXP` = 1 if `R_DIV` ≤ 2, else `R_DIV`.
- `LOCK_CNT`, default 4: number of consecutive good half-periods required to assert lock. Range 1..15.
- `TOL`, default 0: allowed deviation, in `clk_in` cycles, of a half-period from its expected value.
- `CNT_W`, default 16: width of the measurement counters and half-period outputs.
- `clk_in` input 1: the single clock (the undivided source clock).
- `rst` input 1: synchronous, active-high reset.
- `w_clk_mon` input 1: monitored write clock.
- `r_clk_mon` input 1: monitored read clock.
- `clr_fault` input 1: synchronous clear of both sticky fault flags.
- `w_locked` output 1: write channel locked.
- `r_locked` output 1: read channel locked.
- `w_fault` output 1: sticky write-channel fault.
- `r_fault` output 1: sticky read-channel fault.
- `w_halfper` output `CNT_W`: last measured write half-period.
- `r_halfper` output `CNT_W`: last measured read half-period.

## Operation
- The two channels are identical and independent; the description below covers one channel.
- **Sampling and edge detection:** the monitored clock passes through a 2-flop synchronizer into `s2`, then one more flop into `s3`. `edge` = `s2` XOR `s3`, so both rising and falling edges are counted.
- **Interval counter `run`:**
  - On `edge`: `run` is loaded with 1.
  - Otherwise: `run` increments, saturating at all-ones.
- **Interval measurement:** on `edge`, if the channel is not in IDLE, `halfper` is loaded with `run` (the cycle count between consecutive edges).
- **Good interval:** |`run` − EXP| ≤ `TOL`.
- **State machine:**
  - IDLE: the first `edge` moves to ACQ. No measurement is taken on this edge and `good` = 0.
  - ACQ, on a good interval: `good` increments. When `good` reaches `LOCK_CNT`, the state moves to LOCK and `locked` = 1.
  - ACQ, on a bad interval: `good` is cleared and the state stays in ACQ.
  - LOCK, on a good interval: the state stays in LOCK.
  - LOCK, on a bad interval: the state moves to ACQ, `good` is cleared, `locked` = 0, and `fault` is set.
- **Fault flag:** `fault` is sticky and is cleared only by `clr_fault` or `rst`. If a fault set and `clr_fault` occur in the same cycle, the set wins.
- **Reset:** `rst` returns all flops to their reset values regardless of state, including mid-acquisition.
- **Out-of-range expectations:** a `halfper` value exceeding `CNT_W` bits saturates. An EXP value ≥ 2^`CNT_W` − 1 is illegal.

## Timing
- Reset values: `w_locked`, `r_locked`, `w_fault`, `r_fault` = 0; `w_halfper`, `r_halfper` = 0; `run` = 0; `good` = 0; state = IDLE; synchronizer flops = 0.
- An input transition is first captured at clock edge k. `edge` is high during the cycle after edge k+2, and the registered outputs change at edge k+3.
- Detection latency is fixed, so measured intervals are exact for inputs that are synchronous to `clk_in`.
- `locked` rises on the clock edge that processes the (`LOCK_CNT`+1)-th detected edge after leaving IDLE.
- With `W_DIV` ≤ 2, the input toggles every cycle, `edge` is high every cycle, and `halfper` = 1.

## Configuration
- Macro: `CLKMON_STALL_DETECT_EN`.
- **Defined:** if no `edge` occurs and `run` reaches EXP+`TOL`+1, this is treated as one bad interval in that cycle. In LOCK it causes the LOCK→ACQ transition and sets `fault`; in ACQ it clears `good`. It fires once per stall: no re-fire until the next `edge`. `halfper` is not updated by a stall event.
- **Not defined:** a stopped clock is detected only when its next edge arrives with a long interval. A clock that never restarts leaves `locked` asserted.

## Test plan
- **Lock on nominal clocks:** with `W_DIV`=12, `R_DIV`=20, `LOCK_CNT`=4 and a reference divider driving the inputs → `w_halfper`=12 and `r_halfper`=20. `w_locked` rises at the 5th detected write edge and `r_locked` at the 5th read edge. Both faults stay 0.
- **Glitched half-period:** while write is locked, stretch one write half-period to 14 → `w_locked` falls, `w_fault`=1, `w_halfper`=14. Lock returns after 4 further 12-cycle halves, and `w_fault` stays 1.
- **Stall detection (`CLKMON_STALL_DETECT_EN` defined):** hold `r_clk_mon` constant while locked → `r_locked` falls and `r_fault`=1 when `run`=21, with `r_halfper` unchanged. Without the macro, `r_locked` remains 1.
- **Clear/set collision:** assert `clr_fault` in the same cycle as a write bad-interval event → `w_fault`=1. Assert `clr_fault` on a later cycle → `w_fault`=0 and `r_fault`=0.
- **Reset mid-acquisition:** assert `rst` for 1 cycle after 2 good write intervals → all outputs 0. The first post-reset edge produces no `halfper` update, and relock requires 4 more good intervals.
- **Divide-by-2 corner:** `W_DIV`=2 with `w_clk_mon` toggling every cycle → `w_halfper`=1 and `w_locked`=1 after 5 edges.
